// File: rtl/ysyx_lsu_sram_if.sv
// LSU-side load/store bus between the LSU (master) and a word SRAM (slave).
// Carries the load address/response channel and the store address/data/done channel.
interface ysyx_lsu_sram_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // load channel
  logic [ADDR_W-1:0] lsu_araddr;
  logic              lsu_arvalid;
  logic [7:0]        lsu_rstrb;
  logic [DATA_W-1:0] lsu_rdata;
  logic              lsu_rvalid;
  // store channel
  logic [ADDR_W-1:0] lsu_awaddr;
  logic              lsu_awvalid;
  logic [DATA_W-1:0] lsu_wdata;
  logic [7:0]        lsu_wstrb;
  logic              lsu_wvalid;
  logic              lsu_wready;

  modport master (
    output lsu_araddr, lsu_arvalid, lsu_rstrb,
    input  lsu_rdata, lsu_rvalid,
    output lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb, lsu_wvalid,
    input  lsu_wready
  );

  modport slave (
    input  lsu_araddr, lsu_arvalid, lsu_rstrb,
    output lsu_rdata, lsu_rvalid,
    input  lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb, lsu_wvalid,
    output lsu_wready
  );
endinterface

// File: rtl/ysyx_lsu_sram.sv
// Word-organised SRAM responder for the LSU load/store bus.
// One transaction at a time: accept in IDLE, wait LATENCY cycles, then pulse
// lsu_rvalid (aligned word) or lsu_wready (after committing byte lanes).
// Optional feature macro: YSYX_LSU_SRAM_RAND_DELAY_EN adds a 0..3 cycle
// LFSR-driven extra delay at each accept.
module ysyx_lsu_sram #(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter int          DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  ysyx_lsu_sram_if.slave    bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Counter must hold LATENCY-1 plus the largest random extra delay (3).
  localparam int CNT_W = $clog2(LATENCY + 4);
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LD  = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [3:0]         wstrb_q;
  logic               rvalid_q, wready_q;
  logic [DATA_W-1:0]  rdata_q;

  logic               load_wr, load_rd;
  logic               resp_rd, resp_wr;
  logic [1:0]         extra_dly;

  // Size strobe on loads and the upper store strobe bits carry no information here.
  logic unused_strb;
  assign unused_strb = ^{bus.lsu_rstrb, bus.lsu_wstrb[7:4]};

`ifdef YSYX_LSU_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_q;
  logic       lfsr_fb;
  // x^8+x^6+x^5+x^4+1 Fibonacci feedback
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  // Free-running LFSR; its low bits pick the extra delay at accept time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 8'hA5;
    else        lfsr_q <= {lfsr_q[6:0], lfsr_fb};
  end
  assign extra_dly = lfsr_q[1:0];
`else
  assign extra_dly = 2'd0;
`endif

  // Address decode of the latched request address.
  logic [ADDR_W-1:0] offset;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  assign offset   = addr_q - BASE_A;
  assign in_range = (addr_q >= BASE_A) && ((offset >> 2) < DEPTH_A);
  assign idx      = offset[IDX_W+1:2];

  // Byte lanes past bit 31 fall off the top: no cross-word split.
  logic [3:0]        lane_en;
  logic [DATA_W-1:0] wshift;
  assign lane_en = wstrb_q << addr_q[1:0];
  assign wshift  = wdata_q << {addr_q[1:0], 3'b000};

  logic mem_we;
  assign mem_we = resp_wr && in_range;

  // FSM next-state and control: store wins over load when both are present.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_wr = 1'b0;
    load_rd = 1'b0;
    resp_rd = 1'b0;
    resp_wr = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.lsu_awvalid && bus.lsu_wvalid) begin
          load_wr = 1'b1;
          cnt_d   = CNT_LD + CNT_W'(extra_dly);
          state_d = WR_WAIT;
        end else if (bus.lsu_arvalid) begin
          load_rd = 1'b1;
          cnt_d   = CNT_LD + CNT_W'(extra_dly);
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          resp_rd = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_WAIT: begin
        if (cnt_q == '0) begin
          resp_wr = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and counter registers; reset aborts any pending transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture: address/data/strobe are only sampled at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (load_wr) begin
      addr_q  <= bus.lsu_awaddr;
      wdata_q <= bus.lsu_wdata;
      wstrb_q <= bus.lsu_wstrb[3:0];
    end else if (load_rd) begin
      addr_q  <= bus.lsu_araddr;
    end
  end

  // Storage array, never reset; byte-lane write on the wready edge.
  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[idx][8*b +: 8] <= wshift[8*b +: 8];
      end
    end
  end

  // Registered read data and one-cycle response pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      wready_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= resp_rd;
      wready_q <= resp_wr;
      if (resp_rd) rdata_q <= in_range ? mem[idx] : '0;
    end
  end

  assign bus.lsu_rvalid = rvalid_q;
  assign bus.lsu_wready = wready_q;
  assign bus.lsu_rdata  = rdata_q;

endmodule

// File: tb/tb_ysyx_lsu_sram.sv
// Scoreboard bench for ysyx_lsu_sram: the driver pushes expected responses,
// an independent monitor pops and checks on every lsu_rvalid/lsu_wready.
module tb_ysyx_lsu_sram;
  localparam int          LAT  = 2;
  localparam logic [31:0] BASE = 32'h8000_0000;
`ifdef YSYX_LSU_SRAM_RAND_DELAY_EN
  localparam int LAT_MAX = LAT + 3;
`else
  localparam int LAT_MAX = LAT;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_lsu_sram_if bus ();

  ysyx_lsu_sram #(.LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          acc_cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [16];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'h1000);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (!in_rng(a)) return 32'h0;
    return model[off[5:2]];
  endfunction

  // Byte-by-byte reference: memory byte b takes data byte (b-off) when that strobe bit is set.
  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] off;
    int o;
    off = a - BASE;
    o = int'(a[1:0]);
    if (in_rng(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (b >= o && s[b-o]) model[off[5:2]][8*b +: 8] = d[8*(b-o) +: 8];
      end
    end
  endtask

  // Wait (bounded) for the chosen response, sampled #1 after the edge.
  task automatic wait_resp(input bit is_wr, input string name);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      seen = is_wr ? bus.lsu_wready : bus.lsu_rvalid;
    end
    chk({name, "_timeout"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic xfer(input bit is_wr, input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
    exp_t e;
    @(negedge clk);
    e.is_wr   = is_wr;
    e.addr    = a;
    e.acc_cyc = cyc + 1;
    if (is_wr) begin
      e.data = 32'h0;
      model_write(a, d, s[3:0]);
      bus.lsu_awaddr  = a;
      bus.lsu_wdata   = d;
      bus.lsu_wstrb   = s;
      bus.lsu_awvalid = 1'b1;
      bus.lsu_wvalid  = 1'b1;
    end else begin
      e.data = model_read(a);
      bus.lsu_araddr  = a;
      bus.lsu_rstrb   = s;
      bus.lsu_arvalid = 1'b1;
    end
    sb_q.push_back(e);
    wait_resp(is_wr, is_wr ? "store" : "load");
    // still inside the response cycle: drop valids before the edge that ends it
    bus.lsu_awvalid = 1'b0;
    bus.lsu_wvalid  = 1'b0;
    bus.lsu_arvalid = 1'b0;
  endtask

  // Monitor: one line per response, checks kind, data and latency.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.lsu_rvalid || bus.lsu_wready) begin
        chk("single_resp", {31'd0, bus.lsu_rvalid & bus.lsu_wready}, 32'd0);
        if (sb_q.size() == 0) begin
          chk("unexpected_resp", {30'd0, bus.lsu_wready, bus.lsu_rvalid}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("resp_kind", {31'd0, bus.lsu_wready}, {31'd0, e.is_wr});
          if (!e.is_wr) chk("rdata", bus.lsu_rdata, e.data);
          n_checks++;
          if ((cyc - e.acc_cyc) < LAT || (cyc - e.acc_cyc) > LAT_MAX) begin
            n_fail++;
            $display("FAIL latency: got %0d, required %0d..%0d", cyc - e.acc_cyc, LAT, LAT_MAX);
          end
          $display("resp %s addr=%h rdata=%h lat=%0d", e.is_wr ? "WR" : "RD", e.addr,
                   bus.lsu_rdata, cyc - e.acc_cyc);
        end
      end
    end
  end

  // Watchdog in case something outside the bounded waits stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [31:0] a, d;
    logic [7:0]  s;
    int k;

    bus.lsu_araddr = '0; bus.lsu_arvalid = 1'b0; bus.lsu_rstrb = '0;
    bus.lsu_awaddr = '0; bus.lsu_awvalid = 1'b0; bus.lsu_wdata = '0;
    bus.lsu_wstrb  = '0; bus.lsu_wvalid  = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid", {31'd0, bus.lsu_rvalid}, 32'd0);
    chk("rst_wready", {31'd0, bus.lsu_wready}, 32'd0);
    chk("rst_rdata", bus.lsu_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // give the modelled window known contents
    for (int i = 0; i < 16; i++) xfer(1'b1, BASE + 32'(4*i), 32'h0, 8'h0f);

    // SW then LW
    xfer(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0f);
    xfer(1'b0, 32'h8000_0010, 32'h0, 8'h0f);

    // byte lanes: SB at +3, SH at +0 -> AB00_1234
    xfer(1'b1, 32'h8000_0023, 32'h0000_00AB, 8'h01);
    xfer(1'b1, 32'h8000_0020, 32'h0000_1234, 8'h03);
    xfer(1'b0, 32'h8000_0020, 32'h0, 8'h0f);
    chk("lanes_model", model_read(32'h8000_0020), 32'hAB00_1234);

    // simultaneous load + store: store first, held load served next
    @(negedge clk);
    e.is_wr = 1'b1; e.addr = BASE; e.data = 32'h0; e.acc_cyc = cyc + 1;
    model_write(BASE, 32'h55, 4'hf);
    bus.lsu_awaddr = BASE; bus.lsu_wdata = 32'h55; bus.lsu_wstrb = 8'h0f;
    bus.lsu_araddr = BASE; bus.lsu_rstrb = 8'h0f;
    bus.lsu_awvalid = 1'b1; bus.lsu_wvalid = 1'b1; bus.lsu_arvalid = 1'b1;
    sb_q.push_back(e);
    wait_resp(1'b1, "simul_store");
    bus.lsu_awvalid = 1'b0; bus.lsu_wvalid = 1'b0;
    e.is_wr = 1'b0; e.addr = BASE; e.data = 32'h0000_0055; e.acc_cyc = cyc + 1;
    sb_q.push_back(e);
    wait_resp(1'b0, "simul_load");
    bus.lsu_arvalid = 1'b0;

    // out of range
    xfer(1'b0, 32'h0000_0100, 32'h0, 8'h0f);
    xfer(1'b1, 32'h9000_0000, 32'hFFFF_FFFF, 8'h0f);
    xfer(1'b0, 32'h8000_0000, 32'h0, 8'h0f);
    xfer(1'b0, 32'h8000_0010, 32'h0, 8'h0f);

    // reset during WR_WAIT: no response, no commit
    xfer(1'b1, 32'h8000_0004, 32'h0, 8'h0f);
    @(negedge clk);
    bus.lsu_awaddr = 32'h8000_0004; bus.lsu_wdata = 32'h1111_1111; bus.lsu_wstrb = 8'h0f;
    bus.lsu_awvalid = 1'b1; bus.lsu_wvalid = 1'b1;
    @(negedge clk);
    bus.lsu_awvalid = 1'b0; bus.lsu_wvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_rdata", bus.lsu_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    xfer(1'b0, 32'h8000_0004, 32'h0, 8'h0f);

    // mixed random traffic over the modelled window plus occasional out-of-range
    for (int i = 0; i < 100; i++) begin
      k = $urandom_range(0, 9);
      if (k == 0)      a = 32'h0000_0100 + 32'($urandom_range(0, 15));
      else if (k == 1) a = 32'h9000_0000 + 32'($urandom_range(0, 15));
      else             a = BASE + 32'($urandom_range(0, 63));
      d = $urandom;
      case ($urandom_range(0, 2))
        0:       s = 8'h01;
        1:       s = 8'h03;
        default: s = 8'h0f;
      endcase
      xfer($urandom_range(0, 1) == 1, a, d, s);
    end
    for (int i = 0; i < 16; i++) xfer(1'b0, BASE + 32'(4*i), 32'h0, 8'h0f);

    repeat (10) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
